// File: rtl/cgra_tile_cfg_mem.sv
// -----------------------------------------------------------------------------
// cgra_tile_cfg_mem
//
// Tile-side configuration memory for one CGRA tile. The CSR block writes
// KernelSize configuration words into a local memory over a valid/ready
// interface, and a bitmap records which entries have been loaded. A start
// command replays the kernel into the tile datapath. Replay issues one entry
// per cycle, for a programmed number of full passes.
//
// Config word layout (49 bits):
//   [48:43] ctrl   [42] predicate   [41:30] fu_in   [29:6] outport
//   [5:0]   predicate_in
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   cfg_tile_addr_i        write entry index
//   cfg_tile_data_i        config word to store
//   cfg_tile_wr_en_i       write enable qualifier
//   cfg_tile_wr_valid_i    write request valid
//   cfg_tile_ready_o       write request ready (high only while IDLE)
//   clear_i                clears the loaded bitmap (memory untouched)
//   start_i                start replay pulse
//   iter_count_i           number of kernel passes, sampled on accepted start
//   stall_i                hold the replay pointer this cycle
//   ctrl_o                 config word issued to the datapath
//   ctrl_addr_o            entry index of ctrl_o
//   ctrl_valid_o           ctrl_o issued this cycle
//   loaded_o               every entry written since last clear/reset
//   busy_o                 replay in progress
//   done_o                 pulse alongside the last issued entry
// -----------------------------------------------------------------------------
module cgra_tile_cfg_mem #(
    parameter int  KernelSize = 4,
    parameter int  IterWidth  = 16,
    localparam int AddrW      = $clog2(KernelSize),
    localparam int CfgW       = 49
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrW-1:0]     cfg_tile_addr_i,
    input  logic [CfgW-1:0]      cfg_tile_data_i,
    input  logic                 cfg_tile_wr_en_i,
    input  logic                 cfg_tile_wr_valid_i,
    output logic                 cfg_tile_ready_o,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [IterWidth-1:0] iter_count_i,
    input  logic                 stall_i,
    output logic [CfgW-1:0]      ctrl_o,
    output logic [AddrW-1:0]     ctrl_addr_o,
    output logic                 ctrl_valid_o,
    output logic                 loaded_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CfgW-1:0]        r_mem [KernelSize];
    logic [KernelSize-1:0]  r_written;
    logic [AddrW-1:0]       r_ptr;
    logic [IterWidth-1:0]   r_iter_rem;

    logic [CfgW-1:0]        r_ctrl;
    logic [AddrW-1:0]       r_ctrl_addr;
    logic                   r_ctrl_valid;
    logic                   r_done;

    logic                   w_idle;
    logic                   w_addr_in_range;
    logic                   w_wr_accept;
    logic                   w_start_accept;
    logic                   w_ptr_wrap;
    logic                   w_last_issue;
    logic [KernelSize-1:0]  w_wr_bit;
    logic [KernelSize-1:0]  w_written_nxt;

    assign w_idle           = (r_state == S_IDLE);
    assign cfg_tile_ready_o = w_idle;
    assign loaded_o         = &r_written;
    assign busy_o           = (r_state == S_RUN);

    // Out-of-range addresses still complete the handshake; the data is dropped.
    assign w_addr_in_range = (32'(cfg_tile_addr_i) < 32'(KernelSize));
    assign w_wr_accept     = cfg_tile_wr_valid_i && cfg_tile_wr_en_i && w_idle
                             && w_addr_in_range;

    // loaded_o reflects the bitmap before any same-cycle write.
    assign w_start_accept = w_idle && start_i && loaded_o && (iter_count_i != '0);

    assign w_ptr_wrap   = (r_ptr == AddrW'(KernelSize - 1));
    assign w_last_issue = !stall_i && w_ptr_wrap && (r_iter_rem == IterWidth'(1));

    // A write landing in the same cycle as clear_i survives the clear.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wr_bit = '0;
        if (w_wr_accept) begin
            w_wr_bit[cfg_tile_addr_i] = 1'b1;
        end
        w_written_nxt = (clear_i ? '0 : r_written) | w_wr_bit;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_accept) w_state_nxt = S_RUN;
            S_RUN:  if (w_last_issue)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the config memory sits in the reset domain because the kernel
    // must read back as all-zero after reset. It is small enough to live in
    // flops rather than a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < KernelSize; i++) begin
                r_mem[i] <= '0;
            end
            r_written    <= '0;
            r_ptr        <= '0;
            r_iter_rem   <= '0;
            r_ctrl       <= '0;
            r_ctrl_addr  <= '0;
            r_ctrl_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_written <= w_written_nxt;
            if (w_wr_accept) begin
                r_mem[cfg_tile_addr_i] <= cfg_tile_data_i;
            end

            unique case (r_state)
                S_IDLE: begin
                    r_ctrl       <= '0;
                    r_ctrl_addr  <= '0;
                    r_ctrl_valid <= 1'b0;
                    r_done       <= 1'b0;
                    if (w_start_accept) begin
                        r_ptr      <= '0;
                        r_iter_rem <= iter_count_i;
                    end
                end
                S_RUN: begin
                    r_done <= 1'b0;
                    if (stall_i) begin
                        r_ctrl_valid <= 1'b0;
                    end else begin
                        r_ctrl       <= r_mem[r_ptr];
                        r_ctrl_addr  <= r_ptr;
                        r_ctrl_valid <= 1'b1;
                        if (w_ptr_wrap) begin
                            r_ptr      <= '0;
                            // Counts down from the sampled value, so the
                            // full range of iter_count_i needs no extra bit.
                            r_iter_rem <= r_iter_rem - IterWidth'(1);
                            r_done     <= (r_iter_rem == IterWidth'(1));
                        end else begin
                            r_ptr <= r_ptr + AddrW'(1);
                        end
                    end
                end
                default: begin
                    r_ctrl_valid <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_o       = r_ctrl;
    assign ctrl_addr_o  = r_ctrl_addr;
    assign ctrl_valid_o = r_ctrl_valid;
    assign done_o       = r_done;

endmodule

// File: tb/tb_cgra_tile_cfg_mem.sv
// -----------------------------------------------------------------------------
// tb_cgra_tile_cfg_mem
//
// Self-checking bench for cgra_tile_cfg_mem. A behavioural model predicts
// every output after each clock edge. The model tracks the memory contents,
// the loaded bitmap, and a replay expressed as "issue number n of
// iter*KernelSize reads entry n mod KernelSize". Directed scenarios come
// first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_cgra_tile_cfg_mem;

    localparam int K     = 4;
    localparam int IW    = 16;
    localparam int AW    = $clog2(K);
    localparam int CW    = 49;

    logic          clk;
    logic          rst;
    logic [AW-1:0] cfg_tile_addr;
    logic [CW-1:0] cfg_tile_data;
    logic          cfg_tile_wr_en;
    logic          cfg_tile_wr_valid;
    logic          cfg_tile_ready;
    logic          clear;
    logic          start;
    logic [IW-1:0] iter_count;
    logic          stall;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] ctrl_addr;
    logic          ctrl_valid;
    logic          loaded;
    logic          busy;
    logic          done;

    cgra_tile_cfg_mem #(.KernelSize(K), .IterWidth(IW)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cfg_tile_addr_i     (cfg_tile_addr),
        .cfg_tile_data_i     (cfg_tile_data),
        .cfg_tile_wr_en_i    (cfg_tile_wr_en),
        .cfg_tile_wr_valid_i (cfg_tile_wr_valid),
        .cfg_tile_ready_o    (cfg_tile_ready),
        .clear_i             (clear),
        .start_i             (start),
        .iter_count_i        (iter_count),
        .stall_i             (stall),
        .ctrl_o              (ctrl),
        .ctrl_addr_o         (ctrl_addr),
        .ctrl_valid_o        (ctrl_valid),
        .loaded_o            (loaded),
        .busy_o              (busy),
        .done_o              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [CW-1:0] m_mem [K];
    logic [K-1:0]  m_written;
    bit            m_busy;
    int            m_total;
    int            m_issued;
    logic [CW-1:0] exp_ctrl;
    logic [AW-1:0] exp_addr;
    logic          exp_valid;
    logic          exp_done;

    int n_checks;
    int n_pass;
    int n_valid_seen;
    int n_done_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < K; i++) m_mem[i] = '0;
        m_written = '0;
        m_busy    = 1'b0;
        m_total   = 0;
        m_issued  = 0;
        exp_ctrl  = '0;
        exp_addr  = '0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
    endtask

    // Applies the inputs present at this clock edge to the model.
    task automatic model_edge();
        bit           pre_busy;
        bit           loaded_pre;
        logic [K-1:0] wbit;
        int           idx;
        if (rst) begin
            model_reset();
            return;
        end
        pre_busy   = m_busy;
        loaded_pre = &m_written;
        wbit       = '0;
        if (cfg_tile_wr_valid && cfg_tile_wr_en && !pre_busy && int'(cfg_tile_addr) < K) begin
            m_mem[cfg_tile_addr] = cfg_tile_data;
            wbit[cfg_tile_addr]  = 1'b1;
        end
        m_written = (clear ? '0 : m_written) | wbit;
        if (!pre_busy) begin
            exp_valid = 1'b0;
            exp_ctrl  = '0;
            exp_addr  = '0;
            exp_done  = 1'b0;
            if (start && loaded_pre && iter_count != '0) begin
                m_busy   = 1'b1;
                m_total  = int'(iter_count) * K;
                m_issued = 0;
            end
        end else begin
            exp_done = 1'b0;
            if (stall) begin
                exp_valid = 1'b0;
            end else begin
                idx       = m_issued % K;
                exp_addr  = AW'(idx);
                exp_ctrl  = m_mem[idx];
                exp_valid = 1'b1;
                m_issued++;
                if (m_issued == m_total) begin
                    exp_done = 1'b1;
                    m_busy   = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ctrl_valid", ctrl_valid, exp_valid);
        check("done", done, exp_done);
        check("busy", busy, m_busy);
        check("ready", cfg_tile_ready, !m_busy);
        check("loaded", loaded, &m_written);
        check("ctrl", ctrl, exp_ctrl);
        check("ctrl_addr", ctrl_addr, exp_addr);
    endtask

    // One clock: model follows the edge, outputs are compared 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (ctrl_valid) n_valid_seen++;
        if (done)       n_done_seen++;
    endtask

    task automatic idle_inputs();
        cfg_tile_addr     = '0;
        cfg_tile_data     = '0;
        cfg_tile_wr_en    = 1'b0;
        cfg_tile_wr_valid = 1'b0;
        clear             = 1'b0;
        start             = 1'b0;
        iter_count        = '0;
        stall             = 1'b0;
    endtask

    function automatic logic [CW-1:0] word(input int c);
        logic [CW-1:0] w;
        w = CW'({$urandom(), $urandom()});
        w[48:43] = 6'(c);
        return w;
    endfunction

    task automatic write(input int a, input logic [CW-1:0] d);
        cfg_tile_addr     = AW'(a);
        cfg_tile_data     = d;
        cfg_tile_wr_en    = 1'b1;
        cfg_tile_wr_valid = 1'b1;
        step();
        cfg_tile_wr_en    = 1'b0;
        cfg_tile_wr_valid = 1'b0;
    endtask

    task automatic pulse_start(input int it);
        start      = 1'b1;
        iter_count = IW'(it);
        step();
        start      = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop at once.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        step();
        #2;
        rst = 1'b0;
        step();
        check("ready_after_reset", cfg_tile_ready, 1'b1);
        check("loaded_after_reset", loaded, 1'b0);
    endtask

    initial begin
        bit was_ready;
        bit was_done;
        bit found;
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        compare_all();
        step();
        #2;
        rst = 1'b0;
        step();

        // Basic replay: ctrl 1..4, one pass.
        for (int i = 0; i < K; i++) write(i, word(i + 1));
        check("loaded_full", loaded, 1'b1);
        pulse_start(1);
        for (int i = 0; i < 8; i++) step();

        // Partial load: start ignored until the last entry arrives.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) write(i, word(i + 9));
        pulse_start(1);
        step();
        check("start_ignored_busy", busy, 1'b0);
        check("start_ignored_loaded", loaded, 1'b0);
        write(3, word(12));
        check("loaded_after_e3", loaded, 1'b1);
        pulse_start(2);
        for (int i = 0; i < 10; i++) step();

        // Three passes with two stall cycles: 12 issues, one done.
        n_valid_seen = 0;
        n_done_seen  = 0;
        pulse_start(3);
        for (int c = 1; c <= 20; c++) begin
            stall = (c == 2 || c == 7);
            step();
        end
        stall = 1'b0;
        check("stall_issue_count", n_valid_seen, 12);
        check("stall_done_count", n_done_seen, 1);

        // Write held during RUN completes in the cycle done_o is high.
        pulse_start(1);
        cfg_tile_addr     = AW'(1);
        cfg_tile_data     = word(33);
        cfg_tile_wr_en    = 1'b1;
        cfg_tile_wr_valid = 1'b1;
        was_ready = 1'b0;
        was_done  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            was_ready = cfg_tile_ready;
            was_done  = done;
            step();
            if (was_ready) break;
        end
        cfg_tile_wr_en    = 1'b0;
        cfg_tile_wr_valid = 1'b0;
        check("held_write_accepted", was_ready, 1'b1);
        check("held_write_after_done", was_done, 1'b1);
        pulse_start(1);
        for (int i = 0; i < 6; i++) step();

        // clear and write to entry 2 together: only bit 2 remains.
        clear             = 1'b1;
        cfg_tile_addr     = AW'(2);
        cfg_tile_data     = word(44);
        cfg_tile_wr_en    = 1'b1;
        cfg_tile_wr_valid = 1'b1;
        step();
        idle_inputs();
        check("clear_write_loaded", loaded, 1'b0);
        write(0, word(5));
        write(1, word(6));
        check("bit2_kept_loaded0", loaded, 1'b0);
        write(3, word(7));
        check("bit2_kept_loaded1", loaded, 1'b1);
        pulse_start(1);
        for (int i = 0; i < 6; i++) step();

        // Randomized phase.
        for (int n = 0; n < 800; n++) begin
            cfg_tile_addr     = AW'($urandom_range(K - 1));
            cfg_tile_data     = CW'({$urandom(), $urandom()});
            cfg_tile_wr_valid = ($urandom_range(1) == 1);
            cfg_tile_wr_en    = ($urandom_range(3) != 0);
            clear             = ($urandom_range(24) == 0);
            start             = ($urandom_range(7) == 0);
            iter_count        = IW'($urandom_range(3));
            stall             = ($urandom_range(4) == 0);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) step();

        // Long run with the maximum iteration count, aborted by reset.
        for (int i = 0; i < K; i++) write(i, word(i + 20));
        pulse_start(16'hFFFF);
        for (int i = 0; i < 150; i++) step();
        check("max_iter_still_busy", busy, 1'b1);
        async_reset();

        // Reset at entry 2 of the first pass: no done_o.
        for (int i = 0; i < K; i++) write(i, word(i + 30));
        n_done_seen = 0;
        pulse_start(2);
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (ctrl_valid && ctrl_addr == AW'(2)) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_entry2", found, 1'b1);
        async_reset();
        check("no_done_on_abort", n_done_seen, 0);

        for (int i = 0; i < 4; i++) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
